// File: rtl/leaf_uplink_if.sv
// Signal bundle between one leaf_uplink, its local host and the spine link.
// The leaf drives the slave side; the host/spine model drives the master side.
interface leaf_uplink_if;
    logic [15:0] tx_in_data;
    logic        tx_in_valid;
    logic        tx_in_ready;
    logic [15:0] up_out_data;
    logic        up_out_valid;
    logic        credit_in;
    logic [15:0] down_in_data;
    logic        down_in_valid;
    logic [15:0] rx_out_data;
    logic        rx_out_valid;
    logic        rx_out_ready;
    logic [7:0]  rx_drop_cnt;
    logic [7:0]  rx_misroute_cnt;
    logic        credit_ovf;

    modport slave (
        input  tx_in_data, tx_in_valid, credit_in, down_in_data, down_in_valid, rx_out_ready,
        output tx_in_ready, up_out_data, up_out_valid, rx_out_data, rx_out_valid,
               rx_drop_cnt, rx_misroute_cnt, credit_ovf
    );

    modport master (
        output tx_in_data, tx_in_valid, credit_in, down_in_data, down_in_valid, rx_out_ready,
        input  tx_in_ready, up_out_data, up_out_valid, rx_out_data, rx_out_valid,
               rx_drop_cnt, rx_misroute_cnt, credit_ovf
    );
endinterface

// File: rtl/leaf_uplink.sv
// Leaf-to-spine uplink: credit-throttled TX packet sender and address-filtering
// RX packet receiver, each with its own FIFO.
module leaf_uplink #(
    parameter logic [3:0] GROUP_ID   = 4'b1000,
    parameter logic [1:0] LEAF_ID    = 2'd1,
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter int         CREDITS    = 8
) (
    input  logic         clk,
    input  logic         reset,
    leaf_uplink_if.slave bus
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [5:0]  MY_ADDR    = {GROUP_ID, LEAF_ID};
    localparam logic [3:0]  CREDIT_MAX = 4'(CREDITS);
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY} tx_state_e;
    typedef enum logic [1:0] {RX_HDR, RX_PAY, RX_DROP} rx_state_e;

    // TX side state
    logic [DWIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [AW:0]       tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    tx_state_e         tx_state_q, tx_state_d, tx_cur;
    logic [3:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]        credit_q, credit_d;
    logic              credit_ovf_q, credit_ovf_d;
    logic              up_valid_q, up_valid_d;
    logic [DWIDTH-1:0] up_data_q, up_data_d;
    logic [DWIDTH-1:0] tx_head;
    logic              tx_empty, tx_full, tx_push, tx_send;

    // RX side state
    logic [DWIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW:0]       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    rx_state_e         rx_state_q, rx_state_d;
    logic [3:0]        rx_cnt_q, rx_cnt_d;
    logic [7:0]        drop_q, drop_d;
    logic [7:0]        mis_q, mis_d;
    logic [3:0]        rx_len;
    logic              rx_empty, rx_full, rx_store, rx_push, rx_pop;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign tx_head  = tx_mem_q[tx_rd_q[AW-1:0]];
    assign tx_push  = bus.tx_in_valid && !tx_full;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        credit_d     = credit_q;
        credit_ovf_d = credit_ovf_q;
        up_valid_d   = 1'b0;
        up_data_d    = up_data_q;
        tx_wr_d      = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;

        // IDLE with a waiting flit is already the header phase, which keeps TX latency at one cycle.
        tx_cur  = (tx_state_q == TX_IDLE && !tx_empty) ? TX_HDR : tx_state_q;
        tx_send = !tx_empty && (credit_q != '0);

        if (tx_send) begin
            up_valid_d = 1'b1;
            up_data_d  = tx_head;
            case (tx_cur)
                TX_HDR: begin
                    tx_cnt_d   = tx_head[3:0];
                    tx_state_d = (tx_head[3:0] != '0) ? TX_PAY : TX_IDLE;
                end
                TX_PAY: begin
                    tx_cnt_d = tx_cnt_q - 4'd1;
                    if (tx_cnt_q == 4'd1) tx_state_d = TX_IDLE;
                end
                default: ;
            endcase
        end else begin
            tx_state_d = tx_cur;
        end
        tx_rd_d = tx_send ? tx_rd_q + PTR_ONE : tx_rd_q;

        if (tx_send && !bus.credit_in) begin
            credit_d = credit_q - 4'd1;
        end else if (!tx_send && bus.credit_in) begin
            if (credit_q == CREDIT_MAX) credit_ovf_d = 1'b1;
            else                        credit_d     = credit_q + 4'd1;
        end
    end

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    assign rx_len   = bus.down_in_data[3:0];
    assign rx_pop   = !rx_empty && bus.rx_out_ready;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        mis_d      = mis_q;
        drop_d     = drop_q;
        rx_store   = 1'b0;

        if (bus.down_in_valid) begin
            case (rx_state_q)
                RX_HDR: begin
                    rx_cnt_d = rx_len;
                    if (bus.down_in_data[15:10] == MY_ADDR) begin
                        rx_store = 1'b1;
                        if (rx_len != '0) rx_state_d = RX_PAY;
                    end else begin
                        if (mis_q != 8'hFF) mis_d = mis_q + 8'd1;
                        if (rx_len != '0) rx_state_d = RX_DROP;
                    end
                end
                RX_PAY, RX_DROP: begin
                    rx_store = (rx_state_q == RX_PAY);
                    rx_cnt_d = rx_cnt_q - 4'd1;
                    if (rx_cnt_q == 4'd1) rx_state_d = RX_HDR;
                end
                default: rx_state_d = RX_HDR;
            endcase
        end

        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        rx_push = rx_store && (!rx_full || rx_pop);
        if (rx_store && !rx_push && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

        rx_wr_d = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
        rx_rd_d = rx_pop  ? rx_rd_q + PTR_ONE : rx_rd_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            credit_q     <= CREDIT_MAX;
            credit_ovf_q <= 1'b0;
            up_valid_q   <= 1'b0;
            up_data_q    <= '0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            rx_state_q   <= RX_HDR;
            rx_cnt_q     <= '0;
            drop_q       <= '0;
            mis_q        <= '0;
        end else begin
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            credit_q     <= credit_d;
            credit_ovf_q <= credit_ovf_d;
            up_valid_q   <= up_valid_d;
            up_data_q    <= up_data_d;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            drop_q       <= drop_d;
            mis_q        <= mis_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= bus.tx_in_data;
        if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= bus.down_in_data;
    end

    assign bus.tx_in_ready     = !tx_full || reset;
    assign bus.up_out_valid    = up_valid_q && !reset;
    assign bus.up_out_data     = reset ? '0 : up_data_q;
    assign bus.rx_out_valid    = !rx_empty && !reset;
    assign bus.rx_out_data     = rx_mem_q[rx_rd_q[AW-1:0]];
    assign bus.rx_drop_cnt     = drop_q;
    assign bus.rx_misroute_cnt = mis_q;
    assign bus.credit_ovf      = credit_ovf_q;
endmodule

// File: tb/tb_leaf_uplink.sv
// Scenario bench for leaf_uplink: default instance plus a CREDITS=2 instance,
// expected flits queued at drive time and popped as the DUT emits them.
module tb_leaf_uplink;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [15:0] exp_up[$];
    logic [15:0] exp_up2[$];
    logic [15:0] exp_rx[$];

    always #5 clk = ~clk;

    leaf_uplink_if bus ();
    leaf_uplink_if bus2 ();

    leaf_uplink dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    leaf_uplink #(.CREDITS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.up_out_valid !== 1'b0 || bus.rx_out_valid !== 1'b0 || bus.tx_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_during: up_v=%b rx_v=%b tx_rdy=%b, required 0 0 1",
                     bus.up_out_valid, bus.rx_out_valid, bus.tx_in_ready);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus.up_out_valid !== 1'b0 || bus.rx_out_valid !== 1'b0 || bus.tx_in_ready !== 1'b1 ||
            bus.up_out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_after: up_v=%b rx_v=%b tx_rdy=%b up_d=%h, required 0 0 1 0000",
                     bus.up_out_valid, bus.rx_out_valid, bus.tx_in_ready, bus.up_out_data);
        end
        n_checks++;
        if (bus.rx_drop_cnt !== 8'd0 || bus.rx_misroute_cnt !== 8'd0 || bus.credit_ovf !== 1'b0 ||
            dut.credit_q !== 4'd8) begin
            n_fail++;
            $display("FAIL reset_cnt: drop=%0d mis=%0d ovf=%b credit=%0d, required 0 0 0 8",
                     bus.rx_drop_cnt, bus.rx_misroute_cnt, bus.credit_ovf, dut.credit_q);
        end
    endtask

    task automatic test_tx_packet();
        logic [15:0] flits [4];
        logic [15:0] exp;
        flits[0] = 16'h8403;
        flits[1] = 16'hA001;
        flits[2] = 16'hA002;
        flits[3] = 16'hA003;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                bus.tx_in_valid = 1'b1;
                bus.tx_in_data  = flits[i];
                exp_up.push_back(flits[i]);
            end else begin
                bus.tx_in_valid = 1'b0;
                bus.tx_in_data  = 16'h0000;
            end
            tick();
            n_checks++;
            if (bus.up_out_valid !== (i >= 1 && i <= 4)) begin
                n_fail++;
                $display("FAIL tx_valid cycle %0d: got %b, required %b", i, bus.up_out_valid, (i >= 1 && i <= 4));
            end
            if (bus.up_out_valid === 1'b1) begin
                n_checks++;
                if (exp_up.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_data: unexpected flit %h, none required", bus.up_out_data);
                end else begin
                    exp = exp_up.pop_front();
                    if (bus.up_out_data !== exp) begin
                        n_fail++;
                        $display("FAIL tx_data: got %h, required %h", bus.up_out_data, exp);
                    end
                end
            end
        end
        n_checks++;
        if (dut.credit_q !== 4'd4 || exp_up.size() != 0) begin
            n_fail++;
            $display("FAIL tx_credit: credit=%0d pending=%0d, required 4 0", dut.credit_q, exp_up.size());
        end
        for (int i = 0; i < 4; i++) begin
            bus.credit_in = 1'b1;
            tick();
        end
        bus.credit_in = 1'b0;
        tick();
        n_checks++;
        if (dut.credit_q !== 4'd8 || bus.credit_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_credit_return: credit=%0d ovf=%b, required 8 0", dut.credit_q, bus.credit_ovf);
        end
    endtask

    task automatic test_credit_stall();
        logic [15:0] flits [4];
        logic [15:0] exp;
        int sent = 0;
        flits[0] = 16'h8403;
        flits[1] = 16'hB001;
        flits[2] = 16'hB002;
        flits[3] = 16'hB003;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                bus2.tx_in_valid = 1'b1;
                bus2.tx_in_data  = flits[i];
                exp_up2.push_back(flits[i]);
            end else begin
                bus2.tx_in_valid = 1'b0;
            end
            // i=8: stalled credit 0 -> 1; i=10,11: credit_in during a pending send, then during the send
            bus2.credit_in = (i == 8 || i == 10 || i == 11);
            tick();
            if (bus2.up_out_valid === 1'b1) begin
                sent++;
                n_checks++;
                exp = (exp_up2.size() != 0) ? exp_up2.pop_front() : 16'hxxxx;
                if (bus2.up_out_data !== exp) begin
                    n_fail++;
                    $display("FAIL stall_data: got %h, required %h", bus2.up_out_data, exp);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (sent != 2) begin
                    n_fail++;
                    $display("FAIL stall_count: sent %0d, required 2", sent);
                end
            end
            if (i == 9 || i == 10) begin
                n_checks++;
                if (sent != 3) begin
                    n_fail++;
                    $display("FAIL stall_one_credit: sent %0d at step %0d, required 3", sent, i);
                end
            end
        end
        n_checks++;
        if (sent != 4 || dut2.credit_q !== 4'd1) begin
            n_fail++;
            $display("FAIL stall_simul_credit: sent=%0d credit=%0d, required 4 1", sent, dut2.credit_q);
        end
        bus2.credit_in = 1'b1;
        tick();
        bus2.credit_in = 1'b0;
        tick();
        n_checks++;
        if (dut2.credit_q !== 4'd2 || bus2.credit_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_credit_return: credit=%0d ovf=%b, required 2 0", dut2.credit_q, bus2.credit_ovf);
        end
    endtask

    task automatic test_rx_match();
        logic [15:0] flits [3];
        logic [15:0] exp;
        flits[0] = 16'h8402;
        flits[1] = 16'h1111;
        flits[2] = 16'h2222;
        bus.rx_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.down_in_valid = (i < 3);
            bus.down_in_data  = (i < 3) ? flits[i] : 16'h0000;
            if (i < 3) exp_rx.push_back(flits[i]);
            tick();
            n_checks++;
            if (bus.rx_out_valid !== (i < 3)) begin
                n_fail++;
                $display("FAIL rx_valid cycle %0d: got %b, required %b", i, bus.rx_out_valid, (i < 3));
            end
            if (bus.rx_out_valid === 1'b1 && exp_rx.size() != 0) begin
                exp = exp_rx.pop_front();
                n_checks++;
                if (bus.rx_out_data !== exp) begin
                    n_fail++;
                    $display("FAIL rx_data: got %h, required %h", bus.rx_out_data, exp);
                end
            end
        end
    endtask

    task automatic test_misroute();
        logic [15:0] flits [4];
        logic [15:0] exp;
        flits[0] = 16'h9002;
        flits[1] = 16'h3333;
        flits[2] = 16'h4444;
        flits[3] = 16'h8400;
        exp_rx.push_back(16'h8400);
        for (int i = 0; i < 5; i++) begin
            bus.down_in_valid = (i < 4);
            bus.down_in_data  = (i < 4) ? flits[i] : 16'h0000;
            tick();
            n_checks++;
            if (bus.rx_out_valid !== (i == 3)) begin
                n_fail++;
                $display("FAIL misroute_valid cycle %0d: got %b, required %b", i, bus.rx_out_valid, (i == 3));
            end
            if (bus.rx_out_valid === 1'b1 && exp_rx.size() != 0) begin
                exp = exp_rx.pop_front();
                n_checks++;
                if (bus.rx_out_data !== exp) begin
                    n_fail++;
                    $display("FAIL misroute_data: got %h, required %h", bus.rx_out_data, exp);
                end
            end
        end
        n_checks++;
        if (bus.rx_misroute_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL misroute_cnt: got %0d, required 1", bus.rx_misroute_cnt);
        end
    endtask

    task automatic test_rx_overflow();
        logic [15:0] exp;
        bus.rx_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.down_in_valid = 1'b1;
            bus.down_in_data  = (i == 0) ? 16'h8409 : 16'h5000 + 16'(i);
            if (i < 8) exp_rx.push_back(bus.down_in_data);
            tick();
        end
        bus.down_in_valid = 1'b0;
        n_checks++;
        if (bus.rx_drop_cnt !== 8'd2 || bus.rx_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: drop=%0d valid=%b, required 2 1", bus.rx_drop_cnt, bus.rx_out_valid);
        end
        // push onto the full FIFO in the same cycle as a pop
        exp = exp_rx.pop_front();
        n_checks++;
        if (bus.rx_out_data !== exp) begin
            n_fail++;
            $display("FAIL ovf_head: got %h, required %h", bus.rx_out_data, exp);
        end
        exp_rx.push_back(16'h8400);
        bus.down_in_valid = 1'b1;
        bus.down_in_data  = 16'h8400;
        bus.rx_out_ready  = 1'b1;
        tick();
        bus.down_in_valid = 1'b0;
        for (int c = 0; c < 20 && exp_rx.size() != 0; c++) begin
            if (bus.rx_out_valid === 1'b1) begin
                exp = exp_rx.pop_front();
                n_checks++;
                if (bus.rx_out_data !== exp) begin
                    n_fail++;
                    $display("FAIL ovf_drain: got %h, required %h", bus.rx_out_data, exp);
                end
            end
            tick();
        end
        n_checks++;
        if (exp_rx.size() != 0 || bus.rx_out_valid !== 1'b0 || bus.rx_drop_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL ovf_final: pending=%0d valid=%b drop=%0d, required 0 0 2",
                     exp_rx.size(), bus.rx_out_valid, bus.rx_drop_cnt);
        end
    endtask

    task automatic test_ovf_and_reset();
        logic [15:0] tx_flits [3];
        tx_flits[0] = 16'h8405;
        tx_flits[1] = 16'hC001;
        tx_flits[2] = 16'hC002;
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        tick();
        n_checks++;
        if (bus.credit_ovf !== 1'b1 || dut.credit_q !== 4'd8) begin
            n_fail++;
            $display("FAIL credit_ovf: ovf=%b credit=%0d, required 1 8", bus.credit_ovf, dut.credit_q);
        end
        // start a TX and an RX packet, then reset while both are in flight
        bus.rx_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.tx_in_valid   = 1'b1;
            bus.tx_in_data    = tx_flits[i];
            bus.down_in_valid = (i < 2);
            bus.down_in_data  = (i == 0) ? 16'h8403 : 16'hD001;
            tick();
        end
        bus.tx_in_valid   = 1'b0;
        bus.down_in_valid = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++;
        if (bus.up_out_valid !== 1'b0 || bus.rx_out_valid !== 1'b0 || bus.tx_in_ready !== 1'b1 ||
            bus.up_out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_out: up_v=%b rx_v=%b tx_rdy=%b up_d=%h, required 0 0 1 0000",
                     bus.up_out_valid, bus.rx_out_valid, bus.tx_in_ready, bus.up_out_data);
        end
        n_checks++;
        if (bus.rx_drop_cnt !== 8'd0 || bus.rx_misroute_cnt !== 8'd0 || bus.credit_ovf !== 1'b0 ||
            dut.credit_q !== 4'd8) begin
            n_fail++;
            $display("FAIL midreset_cnt: drop=%0d mis=%0d ovf=%b credit=%0d, required 0 0 0 8",
                     bus.rx_drop_cnt, bus.rx_misroute_cnt, bus.credit_ovf, dut.credit_q);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.up_out_valid !== 1'b0 || bus.rx_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_abandon cycle %0d: up_v=%b rx_v=%b, required 0 0",
                         i, bus.up_out_valid, bus.rx_out_valid);
            end
        end
        // RX must be back in header phase: a foreign header is counted, not stored
        bus.down_in_valid = 1'b1;
        bus.down_in_data  = 16'h9000;
        bus.tx_in_valid   = 1'b1;
        bus.tx_in_data    = 16'h8400;
        tick();
        bus.down_in_valid = 1'b0;
        bus.tx_in_valid   = 1'b0;
        tick();
        n_checks++;
        if (bus.rx_misroute_cnt !== 8'd1 || bus.rx_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_rx_hdr: mis=%0d rx_v=%b, required 1 0", bus.rx_misroute_cnt, bus.rx_out_valid);
        end
        n_checks++;
        if (bus.up_out_valid !== 1'b1 || bus.up_out_data !== 16'h8400 || dut.tx_state_q !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset_tx_hdr: up_v=%b up_d=%h state=%0d, required 1 8400 0",
                     bus.up_out_valid, bus.up_out_data, dut.tx_state_q);
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.tx_in_valid   = 1'b0;
        bus.tx_in_data    = '0;
        bus.credit_in     = 1'b0;
        bus.down_in_valid = 1'b0;
        bus.down_in_data  = '0;
        bus.rx_out_ready  = 1'b1;
        bus2.tx_in_valid  = 1'b0;
        bus2.tx_in_data   = '0;
        bus2.credit_in    = 1'b0;
        bus2.down_in_valid = 1'b0;
        bus2.down_in_data = '0;
        bus2.rx_out_ready = 1'b1;

        test_reset();
        test_tx_packet();
        test_credit_stall();
        test_rx_match();
        test_misroute();
        test_rx_overflow();
        test_ovf_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule

// File: doc/leaf_uplink.md
LEAF_UPLINK -- requirements
Module: leaf_uplink

Interface
REQ-001 SHALL have parameter GROUP_ID, default 4'b1000, meaning the 4-bit group of this leaf.
REQ-002 SHALL have parameter LEAF_ID, default 1, meaning the 2-bit leaf index within the group.
REQ-003 SHALL have parameter DWIDTH, default 16, meaning the flit width; only 16 is supported.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning the depth of each of the TX and RX FIFOs (power of 2).
REQ-005 SHALL have parameter CREDITS, default 8, meaning the initial and maximum credit count (at most 15).
REQ-006 SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-007 SHALL have tx_in_data  input  16  and tx_in_valid  input  1  for local flits to send.
REQ-008 SHALL have tx_in_ready  output  1, meaning the TX FIFO is not full.
REQ-009 SHALL have up_out_data  output  16  and up_out_valid  output  1, the flit toward the spine leaf-port input.
REQ-010 SHALL have credit_in  input  1, a one-cycle pulse meaning the spine has freed one flit slot.
REQ-011 SHALL have down_in_data  input  16  and down_in_valid  input  1, the flit from the spine leaf-port output.
REQ-012 SHALL have rx_out_data  output  16, rx_out_valid  output  1, rx_out_ready  input  1, the local delivery interface.
REQ-013 SHALL have rx_drop_cnt  output  8  (RX FIFO overflow drops), rx_misroute_cnt  output  8  (discarded packets) and credit_ovf  output  1  (sticky flag).

Function
REQ-014 SHALL use this header flit format: [15:10] destination address {group[3:0], leaf[1:0]}; [9:4] reserved; [3:0] payload length L (0..15); the header SHALL be followed by exactly L payload flits.
REQ-015 SHALL write tx_in_data into the TX FIFO when tx_in_valid and tx_in_ready are both 1; flits offered while the FIFO is full SHALL NOT be accepted.
REQ-016 SHALL run the TX FSM through states IDLE, HDR and PAY.
REQ-017 SHALL move the TX FSM from IDLE to HDR when the TX FIFO is not empty.
REQ-018 SHALL, in HDR, send the header, latch L into a payload counter, then go to PAY if L>0 or to IDLE if L=0.
REQ-019 SHALL, in PAY, send one flit per transfer, decrement the counter, and return to IDLE after the last flit.
REQ-020 SHALL send a flit (registered; up_out_valid=1 for one cycle) only in a cycle where the TX FIFO is non-empty and the credit count is greater than 0; otherwise up_out_valid=0 and the FSM SHALL hold its state.
REQ-021 SHALL have a 1-cycle latency: a flit written to an empty TX FIFO in cycle N, with credit available, SHALL appear on up_out in cycle N+1; back-to-back flits SHALL go out one per cycle.
REQ-022 SHALL decrement the credit count by 1 per sent flit and increment it by 1 per credit_in pulse.
REQ-023 SHALL leave the credit count unchanged when a send and a credit_in occur in the same cycle.
REQ-024 SHALL ignore credit_in when the credit count is already CREDITS (with no simultaneous send), and SHALL set credit_ovf until reset.
REQ-025 SHALL run the RX FSM through states HDR, PAY and DROP, framing every packet by the L field whatever its destination.
REQ-026 SHALL, in HDR, on a valid flit whose [15:10] equals {GROUP_ID, LEAF_ID}, store the header and go to PAY if L>0.
REQ-027 SHALL, in HDR, on a valid flit whose destination does not match, discard the header, increment rx_misroute_cnt, and go to DROP if L>0.
REQ-028 SHALL, in PAY, store each payload flit; in DROP it SHALL discard each payload flit; in both states the count SHALL decrement per valid flit and the FSM SHALL return to HDR after the last flit.
REQ-029 SHALL discard a flit that arrives while the RX FIFO is full, increment rx_drop_cnt, and still advance framing as normal.
REQ-030 SHALL make the RX FIFO first-word-fall-through: a flit stored in cycle N SHALL show rx_out_valid=1 in cycle N+1, and it SHALL pop when rx_out_valid and rx_out_ready are both 1.
REQ-031 SHALL allow a simultaneous push and pop on a full RX FIFO; the push SHALL succeed and no drop SHALL be counted.
REQ-032 SHALL make both counters saturate at 255.

Reset
REQ-033 SHALL, when reset=1 at a clock edge, flush both FIFOs, put the TX FSM in IDLE and the RX FSM in HDR, set the credit count to CREDITS, and clear rx_drop_cnt, rx_misroute_cnt and credit_ovf.
REQ-034 SHALL drive up_out_valid=0, rx_out_valid=0, tx_in_ready=1 and up_out_data=0 during and after reset.
REQ-035 SHALL abandon any packet that is in flight when reset is asserted mid-packet, with no further flits of that packet sent or delivered.

Verification
REQ-036 Bench SHALL cover: write header 16'h8403 (dest 6'b100001, L=3) plus 3 payload flits into the TX FIFO -> 4 flits on up_out over 4 consecutive cycles starting 1 cycle after the first write; credit count goes 8 to 4.
REQ-037 Bench SHALL cover: CREDITS=2, send a 4-flit packet with no credit_in -> 2 flits sent and then stall; a single credit_in pulse -> exactly 1 more flit sent.
REQ-038 Bench SHALL cover: RX header 16'h8402 plus 2 payload flits with rx_out_ready=1 -> 3 flits on rx_out, each 1 cycle after arrival.
REQ-039 Bench SHALL cover: RX header 16'h9002 (dest 6'b100100) plus 2 payload flits, then header 16'h8400 -> rx_misroute_cnt=1, and only 16'h8400 is delivered.
REQ-040 Bench SHALL cover: rx_out_ready=0 while 10 matching flits arrive -> 8 stored and rx_drop_cnt=2.
REQ-041 Bench SHALL cover: credit_in pulsed at credit count 8 -> credit_ovf=1 and credit count stays 8; then assert reset mid-packet -> all state back to its reset values.
